// File: rtl/chaos_pkg.sv
// chaos_bit_packer shared types and default widths.
// Pair-filter states and width constants for the bit packer slice.
package chaos_pkg;

  typedef enum logic [1:0] {
    PAIR_EMPTY = 2'd0,
    PAIR_HAVE0 = 2'd1,
    PAIR_HAVE1 = 2'd2
  } pair_state_t;

  localparam int DATA_W_DEF = 16;
  localparam int WORD_W_DEF = 8;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with head word read straight from storage.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_pop, do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rp_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= wdata;
        wp_q        <= wp_q + 1'b1;
      end
      if (do_pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/chaos_bit_packer.sv
// Turns logistic-map vs EWMA comparisons into packed random bytes.
// Optional von Neumann debiasing, stuck-map and dropped-word flags.
module chaos_bit_packer
  import chaos_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int STUCK_LIM  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] xt,
  input  logic [DATA_W-1:0] avg,
  input  logic              debias_en,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              stuck
);

  localparam int CW = $clog2(WORD_W);
  localparam int SW = $clog2(STUCK_LIM + 1);

  logic take, raw_vld, raw_bit;
  logic debias_q;
  pair_state_t state_q, state_d, cur;
  logic emit_vld, emit_bit;

  assign take    = sample_valid && !clear;
  assign raw_vld = take && (xt != avg);
  assign raw_bit = (xt > avg);

  // A mode change restarts pairing from an empty slot.
  assign cur = (debias_en != debias_q) ? PAIR_EMPTY : state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= PAIR_EMPTY;
      debias_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      debias_q <= debias_en;
    end
  end

  always_comb begin
    state_d = cur;
    if (clear || !debias_en) begin
      state_d = PAIR_EMPTY;
    end else if (raw_vld) begin
      unique case (1'b1)
        (cur == PAIR_EMPTY): state_d = raw_bit ? PAIR_HAVE1 : PAIR_HAVE0;
        default:             state_d = PAIR_EMPTY;
      endcase
    end
  end

  always_comb begin
    emit_vld = 1'b0;
    emit_bit = raw_bit;
    if (raw_vld) begin
      if (!debias_en) begin
        emit_vld = 1'b1;
      end else begin
        unique case (1'b1)
          (cur == PAIR_HAVE0): begin
            emit_vld = raw_bit;
            emit_bit = 1'b0;
          end
          (cur == PAIR_HAVE1): begin
            emit_vld = !raw_bit;
            emit_bit = 1'b1;
          end
          default: emit_vld = 1'b0;
        endcase
      end
    end
  end

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q;
  logic              word_done, full, empty, pop;

  assign shift_d   = {shift_q[WORD_W-2:0], emit_bit};
  assign word_done = emit_vld && (cnt_q == CW'(WORD_W - 1));
  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (emit_vld) begin
      shift_q <= shift_d;
      cnt_q   <= word_done ? '0 : cnt_q + 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .push (word_done),
    .wdata(shift_d),
    .pop  (pop),
    .rdata(out_data),
    .full (full),
    .empty(empty)
  );

  logic ovf_q;
  assign overflow = ovf_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          ovf_q <= 1'b0;
    else if (clear)                      ovf_q <= 1'b0;
    else if (word_done && full && !pop)  ovf_q <= 1'b1;
  end

  logic [DATA_W-1:0] prev_q;
  logic              have_q;
  logic [SW-1:0]     scnt_q;

  assign stuck = (scnt_q == SW'(STUCK_LIM));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
      have_q <= 1'b0;
      scnt_q <= '0;
    end else if (clear) begin
      have_q <= 1'b0;
      scnt_q <= '0;
    end else if (sample_valid) begin
      prev_q <= xt;
      have_q <= 1'b1;
      if (have_q && xt == prev_q)
        scnt_q <= stuck ? scnt_q : scnt_q + 1'b1;
      else
        scnt_q <= '0;
    end
  end

endmodule
